// File: rtl/snake_display_pkg.sv
// Shared types and helpers for the snake LED matrix display path.
package snake_display_pkg;

  localparam int NUM_ROWS  = 8;
  localparam int ROW_W     = 8;
  localparam int ROW_IDX_W = 3;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // One-hot row select for a row index
  function automatic logic [ROW_W-1:0] onehot(input logic [ROW_IDX_W-1:0] idx);
    onehot = ROW_W'(1) << idx;
  endfunction

endpackage

// File: rtl/matrix_frame_buffer.sv
// Double buffer for the LED matrix: captures all rows on a display rising
// edge into the shadow copy and promotes shadow to front when told a scan
// frame ends. A capture landing on the swap cycle goes straight to front.
module matrix_frame_buffer
  import snake_display_pkg::*;
(
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_display,
  input  logic [NUM_ROWS-1:0][ROW_W-1:0]     i_rows,
  input  logic                               i_swap,
  output logic [NUM_ROWS-1:0][ROW_W-1:0]     o_front
);

  logic                           r_display_q;
  logic                           r_pending;
  logic [NUM_ROWS-1:0][ROW_W-1:0] r_shadow;
  logic [NUM_ROWS-1:0][ROW_W-1:0] r_front;
  logic                           w_edge;

  assign w_edge  = i_display & ~r_display_q;
  assign o_front = r_front;

  // Edge detect, capture and boundary swap; the newest capture always wins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_display_q <= 1'b0;
      r_pending   <= 1'b0;
      r_shadow    <= '0;
      r_front     <= '0;
    end else begin
      r_display_q <= i_display;
      if (w_edge) r_shadow <= i_rows;
      if (i_swap) begin
        r_pending <= 1'b0;
        if (w_edge)         r_front <= i_rows;
        else if (r_pending) r_front <= r_shadow;
      end else if (w_edge) begin
        r_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed 8x8 LED matrix row scanner with blanking between rows.
// Optional feature macro LED_BLINK_EN adds the blink port and a scan-frame
// counter that blanks the columns on alternating 2^BLINK_LOG2-frame spans.
module led_matrix_scanner
  import snake_display_pkg::*;
#(
  parameter int DWELL_CYCLES   = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int ROW_ACTIVE_LOW = 0,
  parameter int BLINK_LOG2     = 5
) (
  input  logic                 clk_master,
  input  logic                 reset_master,
  input  logic                 display,
  input  logic [ROW_W-1:0]     row_1_main,
  input  logic [ROW_W-1:0]     row_2_main,
  input  logic [ROW_W-1:0]     row_3_main,
  input  logic [ROW_W-1:0]     row_4_main,
  input  logic [ROW_W-1:0]     row_5_main,
  input  logic [ROW_W-1:0]     row_6_main,
  input  logic [ROW_W-1:0]     row_7_main,
  input  logic [ROW_W-1:0]     row_8_main,
`ifdef LED_BLINK_EN
  input  logic                 blink,
`endif
  output logic [ROW_W-1:0]     row_sel,
  output logic [ROW_W-1:0]     col_data,
  output logic [ROW_IDX_W-1:0] scan_row,
  output logic                 frame_start
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // The counter reloads to 0 on entry and counts down through the wrap, so a
  // state of N cycles ends when the counter reads -(N-1) modulo 2^CNT_W.
  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'((1 << CNT_W) - DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'((1 << CNT_W) - BLANK_CYCLES + 1);
  localparam logic [ROW_W-1:0] ROW_IDLE  = (ROW_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(NUM_ROWS - 1);

  scan_state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]               r_cnt, w_cnt_nxt;
  logic [ROW_IDX_W-1:0]           r_row, w_row_nxt;
  logic                           w_boundary;
  logic [ROW_W-1:0]               w_row_sel_nxt, w_col_nxt;
  logic                           w_fs_nxt;
  logic [NUM_ROWS-1:0][ROW_W-1:0] w_rows, w_front;

  assign w_rows = {row_8_main, row_7_main, row_6_main, row_5_main,
                   row_4_main, row_3_main, row_2_main, row_1_main};

  matrix_frame_buffer u_fb (
    .i_clk     (clk_master),
    .i_rst     (reset_master),
    .i_display (display),
    .i_rows    (w_rows),
    .i_swap    (w_boundary),
    .o_front   (w_front)
  );

`ifdef LED_BLINK_EN
  logic [BLINK_LOG2:0] r_frame_cnt;

  // Scan frames completed, drives the blink phase
  always_ff @(posedge clk_master or posedge reset_master) begin
    if (reset_master)    r_frame_cnt <= '0;
    else if (w_boundary) r_frame_cnt <= r_frame_cnt + 1'b1;
  end
`endif

  // Scan FSM state, dwell counter and row index
  always_ff @(posedge clk_master or posedge reset_master) begin
    if (reset_master) begin
      r_state <= BLANK;
      r_cnt   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // Next state plus the output values that go with it
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt - 1'b1;
    w_row_nxt     = r_row;
    w_boundary    = 1'b0;
    w_row_sel_nxt = ROW_IDLE;
    w_col_nxt     = '0;
    w_fs_nxt      = 1'b0;
    case (r_state)
      BLANK: begin
        if (r_cnt == BLANK_END) begin
          w_state_nxt = DRIVE;
          w_cnt_nxt   = '0;
        end
      end
      DRIVE: begin
        if (r_cnt == DWELL_END) begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
          w_row_nxt   = r_row + 1'b1;
          w_boundary  = (r_row == LAST_ROW);
        end
      end
      default: begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
    if (w_state_nxt == DRIVE) begin
      w_row_sel_nxt = onehot(w_row_nxt) ^ ROW_IDLE;
      w_col_nxt     = w_front[w_row_nxt];
`ifdef LED_BLINK_EN
      if (blink && r_frame_cnt[BLINK_LOG2]) w_col_nxt = '0;
`endif
    end
    w_fs_nxt = (r_state == BLANK) && (w_state_nxt == DRIVE) && (w_row_nxt == '0);
  end

  // Registered pin outputs, aligned with the FSM state
  always_ff @(posedge clk_master or posedge reset_master) begin
    if (reset_master) begin
      row_sel     <= ROW_IDLE;
      col_data    <= '0;
      scan_row    <= '0;
      frame_start <= 1'b0;
    end else begin
      row_sel     <= w_row_sel_nxt;
      col_data    <= w_col_nxt;
      scan_row    <= w_row_nxt;
      frame_start <= w_fs_nxt;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboarded directed test of led_matrix_scanner with DWELL=4, BLANK=2.
module tb_led_matrix_scanner;

  localparam int DW = 4;
  localparam int BL = 2;
  localparam int RP = DW + BL;   // row period
  localparam int FP = 8 * RP;    // scan-frame period

  typedef struct packed {
    logic [7:0] rs;
    logic [7:0] cd;
    logic [2:0] sr;
    logic       fs;
    logic       pd;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       display;
  logic [7:0] rows [8];
  logic [7:0] row_sel, col_data;
  logic [2:0] scan_row;
  logic       frame_start;
`ifdef LED_BLINK_EN
  logic       blink;
`endif

  // independent model state
  logic [7:0] m_shadow [8];
  logic [7:0] m_front  [8];
  logic       m_pend;
  logic       m_dq;
  int         c;
  exp_t       q [$];
  int         vectors;
  int         miscompares;

  led_matrix_scanner #(
    .DWELL_CYCLES   (DW),
    .BLANK_CYCLES   (BL),
    .ROW_ACTIVE_LOW (0),
    .BLINK_LOG2     (1)
  ) dut (
    .clk_master   (clk),
    .reset_master (rst),
    .display      (display),
    .row_1_main   (rows[0]),
    .row_2_main   (rows[1]),
    .row_3_main   (rows[2]),
    .row_4_main   (rows[3]),
    .row_5_main   (rows[4]),
    .row_6_main   (rows[5]),
    .row_7_main   (rows[6]),
    .row_8_main   (rows[7]),
`ifdef LED_BLINK_EN
    .blink        (blink),
`endif
    .row_sel      (row_sel),
    .col_data     (col_data),
    .scan_row     (scan_row),
    .frame_start  (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t exp_at(input int cc);
    exp_t e;
    int pos, row, ph;
    pos  = cc % FP;
    row  = pos / RP;
    ph   = pos % RP;
    e.sr = row[2:0];
    e.rs = (ph >= BL) ? 8'(1 << row) : 8'h00;
    e.cd = (ph >= BL) ? m_front[row] : 8'h00;
    e.fs = (pos == BL);
    e.pd = m_pend;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 8'h00;
      m_front[i]  = 8'h00;
    end
    m_pend = 1'b0;
    m_dq   = 1'b0;
    c      = 0;
    q.delete();
  endtask

  // Apply the current inputs to the model for the edge ending cycle c
  task automatic model_edge();
    logic edge_d, bnd;
    edge_d = display && !m_dq;
    m_dq   = display;
    bnd    = ((c % FP) == FP - 1);
    if (bnd) begin
      if (edge_d) begin
        for (int i = 0; i < 8; i++) begin
          m_front[i]  = rows[i];
          m_shadow[i] = rows[i];
        end
      end else if (m_pend) begin
        for (int i = 0; i < 8; i++) m_front[i] = m_shadow[i];
      end
      m_pend = 1'b0;
    end else if (edge_d) begin
      for (int i = 0; i < 8; i++) m_shadow[i] = rows[i];
      m_pend = 1'b1;
    end
  endtask

  task automatic check();
    exp_t e;
    vectors++;
    assert (q.size() > 0) else begin
      miscompares++;
      $error("FAIL scoreboard_empty c=%0d got empty queue exp entry", c);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      assert (row_sel === e.rs) else begin
        miscompares++;
        $error("FAIL row_sel c=%0d got %h exp %h", c, row_sel, e.rs);
      end
      vectors++;
      assert (col_data === e.cd) else begin
        miscompares++;
        $error("FAIL col_data c=%0d got %h exp %h", c, col_data, e.cd);
      end
      vectors++;
      assert (scan_row === e.sr) else begin
        miscompares++;
        $error("FAIL scan_row c=%0d got %0d exp %0d", c, scan_row, e.sr);
      end
      vectors++;
      assert (frame_start === e.fs) else begin
        miscompares++;
        $error("FAIL frame_start c=%0d got %b exp %b", c, frame_start, e.fs);
      end
      vectors++;
      assert (dut.u_fb.r_pending === e.pd) else begin
        miscompares++;
        $error("FAIL pending c=%0d got %b exp %b", c, dut.u_fb.r_pending, e.pd);
      end
    end
  endtask

  // One clock: model the edge, push the expectation, compare after the edge
  task automatic step();
    model_edge();
    q.push_back(exp_at(c + 1));
    @(posedge clk);
    @(negedge clk);
    c++;
    check();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    display     = 1'b0;
`ifdef LED_BLINK_EN
    blink       = 1'b0;
`endif
    for (int i = 0; i < 8; i++) rows[i] = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.push_back(exp_at(0));
    check();

    // capture at cycle 10, then scramble inputs to prove the snapshot holds
    run(10);
    rows[0] = 8'hA5; rows[7] = 8'h3C; display = 1'b1;
    step();
    display = 1'b0; rows[0] = 8'hFF; rows[7] = 8'hFF;
    run(49);

    // two captures in one frame: only the later one reaches the next frame
    rows[0] = 8'h11; rows[4] = 8'h5A; display = 1'b1;
    step();
    display = 1'b0;
    run(9);
    rows[0] = 8'h22; display = 1'b1;
    step();
    display = 1'b0;
    run(72);

    // capture exactly on the frame boundary cycle
    rows[0] = 8'h00; rows[2] = 8'hF0; display = 1'b1;
    step();
    display = 1'b0;
    run(27);

    // asynchronous reset while driving row 4
    #2 rst = 1'b1;
    #1;
    vectors++;
    assert (row_sel === 8'h00) else begin
      miscompares++;
      $error("FAIL async_row_sel got %h exp 00", row_sel);
    end
    vectors++;
    assert (col_data === 8'h00) else begin
      miscompares++;
      $error("FAIL async_col_data got %h exp 00", col_data);
    end
    vectors++;
    assert (scan_row === 3'd0) else begin
      miscompares++;
      $error("FAIL async_scan_row got %0d exp 0", scan_row);
    end
    vectors++;
    assert (frame_start === 1'b0) else begin
      miscompares++;
      $error("FAIL async_frame_start got %b exp 0", frame_start);
    end
    for (int i = 0; i < 8; i++) rows[i] = 8'h00;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.push_back(exp_at(0));
    check();
    run(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Downstream of the snake game core: consumes the eight composed row bytes (snake body OR food) and the core's `display` strobe, then drives a physical 8x8 LED matrix by time-multiplexed row scanning.
- Double-buffered: a frame is captured on each `display` rising edge. It becomes visible only at a scan-frame boundary, so no tearing occurs.
- Inserts a blanking gap between rows to suppress ghosting.

Parameters:
- DWELL_CYCLES, 1000, clock cycles a row is driven (>=1)
- BLANK_CYCLES, 16, clock cycles all rows are off before each row is driven (>=1)
- ROW_ACTIVE_LOW, 0, 1 = invert `row_sel` at the output pins
- BLINK_LOG2, 5, blink half-period is 2^BLINK_LOG2 scan frames (used only with the optional feature)

Ports:
- clk_master  in  1  system clock
- reset_master  in  1  asynchronous, active-high reset
- display  in  1  frame-ready strobe from the clock state machine; the rising edge is the event
- row_1_main..row_8_main  in  8 each  row bitmaps; row_1 is scan index 0, bit 0 is column 0
- row_sel  out  8  one-hot row drive (polarity set by ROW_ACTIVE_LOW)
- col_data  out  8  column data for the driven row, active-high
- scan_row  out  3  index of the current row
- frame_start  out  1  one-cycle pulse on entry to DRIVE of row 0
- blink  in  1  blink request (port exists only with LED_BLINK_EN)

Behaviour:
- Clock and reset: one clock, `clk_master`. `reset_master` is asynchronous and active-high.
- Reset values: state BLANK, scan_row 0, counter 0, shadow and front buffers all 0, pending 0. Outputs: row_sel inactive (0x00, or 0xFF if ROW_ACTIVE_LOW), col_data 0x00, frame_start 0.
- Reset mid-scan aborts immediately to the reset state.
- Edge detect: `display` is registered once. A rising edge is `display & ~display_q`. On an edge, all eight row inputs are copied into the shadow buffer and pending is set.
- Scan FSM has two states, BLANK and DRIVE:
  - BLANK: row_sel inactive, col_data 0. After BLANK_CYCLES cycles, go to DRIVE.
  - DRIVE: row_sel = one-hot(scan_row), col_data = front[scan_row]. After DWELL_CYCLES cycles, go to BLANK with scan_row+1. The index wraps 7->0.
- Counter: one down-counter sized $clog2(max(DWELL,BLANK)+1). It reloads on every state change.
- Frame boundary: the last DRIVE cycle of row 7.
  - If pending is set, front <= shadow and pending is cleared.
- Simultaneous edge and boundary: the freshly sampled rows are written to both shadow and front, and pending stays 0. The newest data wins.
- A second edge before the boundary overwrites the shadow. Only the latest frame is shown.
- Outputs are registered and update on the same edge as the FSM state.
- Latency: a frame captured at cycle t is first visible at row 0 DRIVE of the scan frame after the next boundary.
- Row period is BLANK+DWELL cycles. Scan-frame period is 8*(BLANK+DWELL).
- frame_start fires once per scan frame, on the first DRIVE cycle of row 0.

Optional Feature:
- LED_BLINK_EN defined:
  - Adds the `blink` port and a scan-frame counter of width BLINK_LOG2+1, incremented at each frame boundary.
  - While `blink`=1 and counter[BLINK_LOG2]=1, col_data is forced to 0 during DRIVE. row_sel and timing are unchanged.
  - The counter resets to 0.
- LED_BLINK_EN undefined: no `blink` port, no counter, and col_data is never masked.

Decomposition:
- Package snake_display_pkg:
  - NUM_ROWS=8, ROW_W=8, ROW_IDX_W=3
  - scan_state_t enum {BLANK, DRIVE}
  - one-hot decode function
- Sub-module matrix_frame_buffer: display edge detect, shadow and front registers, pending flag, swap-on-boundary input.
- The scanner top holds the FSM, counter and output flops.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2, ROW_ACTIVE_LOW=0):
- Reset release with rows all 0 -> for 48 cycles, row_sel follows 0x00 x2, 0x01 x4, 0x00 x2, 0x02 x4, … 0x80 x4; col_data=0; frame_start pulses at cycles 2 and 50.
- row_1=0xA5, row_8=0x3C, `display` pulsed at cycle 10 -> col_data unchanged until the boundary at cycle 47; next frame shows 0xA5 while row_sel=0x01 and 0x3C while row_sel=0x80.
- Two `display` edges in one scan frame (row_1=0x11, then 0x22) -> the next frame shows 0x22 only.
- `display` edge exactly on the boundary cycle with row_3=0xF0 -> 0xF0 is shown in the immediately following frame; pending remains 0.
- reset_master asserted asynchronously during DRIVE of row 4 -> row_sel=0x00, col_data=0 and scan_row=0 without waiting for a clock edge; after release, the scan restarts with BLANK of row 0 and buffers read 0.
- With LED_BLINK_EN, BLINK_LOG2=1, blink=1, row_1=0xFF -> col_data is 0xFF in scan frames 0-1, 0x00 in frames 2-3, repeating; with blink=0 it is always 0xFF.
